rv32e_dmem_responder: RTL
=========================

RV32E_DMEM_RESPONDER -- requirements
Module: rv32e_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra cycles between accept and response (0..15).
REQ-004 SHALL have one clock and one reset: asynchronous, active-high.
- clk  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-high.
REQ-005 SHALL have the remaining ports below.
- dmem_addr  input  32  byte address from the CPU data port.
- dmem_wdata  input  32  store data; byte lane i = bits 8i+7:8i.
- dmem_read  input  1  load request.
- dmem_write  input  1  store request.
- dmem_byte_enable  input  4  store lane mask; ignored for loads.
- dmem_rdata  output  32  load data, registered.
- dmem_ready  output  1  one-cycle completion pulse.
- dmem_error  output  1  completion with fault; valid only with dmem_ready.

Function
REQ-006 SHALL implement FSM IDLE, BUSY, DONE.
REQ-007 In IDLE, SHALL accept a request when dmem_read or dmem_write is 1; capture addr, wdata, byte_enable, kind into registers.
REQ-008 Accept from IDLE SHALL go to BUSY with wait counter = WAIT_STATES, or straight to DONE if WAIT_STATES = 0.
REQ-009 BUSY SHALL decrement counter each cycle; go to DONE on the cycle counter reaches 1.
REQ-010 DONE SHALL assert dmem_ready for exactly one cycle, then go to IDLE unconditionally; inputs in BUSY and DONE are ignored.
REQ-011 Latency: accept at edge T yields dmem_ready high in cycle T+1+WAIT_STATES; throughput one access per WAIT_STATES+2 cycles.
REQ-012 Word index SHALL be (addr - BASE_ADDR) >> 2, with 32-bit wrap-around subtraction.
REQ-013 Fault SHALL be set if addr[1:0] != 0, index >= DEPTH_WORDS, or read and write both 1 at accept.
REQ-014 On a faulting access: dmem_error = 1 with dmem_ready, no array write, dmem_rdata = 0.
REQ-015 Non-faulting store SHALL write only lanes with byte_enable bit 1, on the edge entering DONE.
REQ-016 Store with byte_enable = 0 SHALL complete normally, array unchanged.
REQ-017 Store completion SHALL leave dmem_rdata unchanged.
REQ-018 Non-faulting load SHALL return the full word in dmem_rdata during the DONE cycle.
REQ-019 dmem_rdata SHALL hold its value until the next load completion.
REQ-020 dmem_error SHALL be 0 whenever dmem_ready is 0.

Reset
REQ-021 Reset SHALL force IDLE, counter 0, dmem_ready 0, dmem_error 0, dmem_rdata 0.
REQ-022 Reset mid-access SHALL abort with no array write and no dmem_ready pulse.
REQ-023 Storage array contents SHALL NOT be cleared by reset.

Structure
REQ-024 FSM state encodings and default DEPTH_WORDS/WAIT_STATES SHALL live in shared constants.v.
REQ-025 Storage SHALL be a sub-module dmem_ram_array: single port, 32-bit, per-byte write enables, synchronous read.

Verification
REQ-026 WAIT_STATES=1: write addr 0x10, data 0xDEADBEEF, be 4'hF; then read 0x10 -> dmem_ready 2 cycles after each accept, rdata 0xDEADBEEF, error 0.
REQ-027 Write 0x10 data 0x11223344 be 4'b0101 over 0xDEADBEEF, then read -> rdata 0xDE22BE44.
REQ-028 Read 0x13 (misaligned) and read BASE_ADDR+4*DEPTH_WORDS -> dmem_ready with dmem_error 1, rdata 0.
REQ-029 read=write=1 at 0x20 -> error 1, word at 0x20 unchanged on follow-up read.
REQ-030 Write to 0x30 in BUSY, reset pulsed -> no ready pulse, state IDLE; read 0x30 -> prior value.
REQ-031 WAIT_STATES=0: back-to-back reads held high -> ready every 2nd cycle, no duplicate accept in the DONE cycle.

Source files
------------

// File: rtl/rv32e_dmem_responder_pkg.sv
// rtl/rv32e_dmem_responder_pkg.sv - shared constants, FSM encoding and address helpers
package rv32e_dmem_responder_pkg;

   // Default geometry and timing of the responder
   localparam int unsigned DEF_DEPTH_WORDS = 1024;
   localparam int unsigned DEF_WAIT_STATES = 1;

   // Access sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte offset of an address relative to the window base (32-bit wrap-around)
   function automatic logic [31:0] addr_offset(input logic [31:0] addr, input logic [31:0] base);
      return addr - base;
   endfunction

   // A window offset is unusable when it is not word aligned or lands past the last word
   function automatic logic offset_faults(input logic [31:0] offset, input logic [31:0] depth);
      return (offset[1:0] != 2'b00) || ({2'b00, offset[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/rv32e_dmem_responder_if.sv
// rtl/rv32e_dmem_responder_if.sv - CPU data-port bus between a load/store master and the responder
interface rv32e_dmem_responder_if;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_read;
   logic        dmem_write;
   logic [3:0]  dmem_byte_enable;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic        dmem_error;

   modport master (
      output dmem_addr, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
      input  dmem_rdata, dmem_ready, dmem_error
   );

   modport slave (
      input  dmem_addr, dmem_wdata, dmem_read, dmem_write, dmem_byte_enable,
      output dmem_rdata, dmem_ready, dmem_error
   );
endinterface

// File: rtl/rv32e_dmem_responder_ram.sv
// rtl/rv32e_dmem_responder_ram.sv - single-port word RAM with byte lane writes and registered read
module dmem_ram_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
)(
   input  logic          i_clk,
   input  logic          i_en,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];

   // Lane writes when any enable is set, otherwise a synchronous word read; contents have no reset
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we != 4'b0000) begin
            for (int lane = 0; lane < 4; lane++) begin
               if (i_we[lane]) begin
                  r_mem[i_addr][8*lane +: 8] <= i_wdata[8*lane +: 8];
               end
            end
         end else begin
            o_rdata <= r_mem[i_addr];
         end
      end
   end

endmodule

// File: rtl/rv32e_dmem_responder.sv
// rtl/rv32e_dmem_responder.sv - wait-stated data memory responder for an RV32E data port
module rv32e_dmem_responder
   import rv32e_dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
)(
   input  logic                 clk,
   input  logic                 reset,
   rv32e_dmem_responder_if.slave bus
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_count;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_is_read;
   logic        r_is_write;
   logic        r_fault;
   logic [31:0] r_rdata_hold;

   logic        w_accept;
   logic        w_enter_done;
   logic        w_idle;
   logic [31:0] w_op_addr;
   logic [31:0] w_op_wdata;
   logic [3:0]  w_op_be;
   logic        w_cur_read;
   logic        w_cur_write;
   logic        w_cur_fault;
   logic        w_fault_now;
   logic [31:0] w_offset;
   logic        w_ram_en;
   logic [3:0]  w_ram_we;
   logic [31:0] w_ram_q;
   logic [31:0] w_rdata_out;

   // In IDLE the live bus is the operand source so a zero-wait access can reach the RAM on
   // its accept edge; afterwards the captured copy is used and the bus is ignored.
   assign w_idle      = (r_state == ST_IDLE);
   assign w_accept    = w_idle && (bus.dmem_read || bus.dmem_write);
   assign w_op_addr   = w_idle ? bus.dmem_addr        : r_addr;
   assign w_op_wdata  = w_idle ? bus.dmem_wdata       : r_wdata;
   assign w_op_be     = w_idle ? bus.dmem_byte_enable : r_be;
   assign w_cur_read  = w_idle ? bus.dmem_read        : r_is_read;
   assign w_cur_write = w_idle ? bus.dmem_write       : r_is_write;

   // Both request bits at once is a protocol fault on top of address faults
   assign w_offset    = addr_offset(w_op_addr, BASE_ADDR);
   assign w_fault_now = offset_faults(w_offset, 32'(DEPTH_WORDS)) || (bus.dmem_read && bus.dmem_write);
   assign w_cur_fault = w_idle ? w_fault_now : r_fault;

   // Next-state decode; w_enter_done marks the edge on which the RAM is touched
   always_comb begin
      w_next_state = r_state;
      w_enter_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (WAIT_STATES == 0) begin
                  w_next_state = ST_DONE;
                  w_enter_done = 1'b1;
               end else begin
                  w_next_state = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (r_count <= 4'd1) begin
               w_next_state = ST_DONE;
               w_enter_done = 1'b1;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // RAM is only touched by clean accesses; gating with reset keeps an aborted store out of the array
   assign w_ram_en = w_enter_done && !w_cur_fault && !reset && (w_cur_read || (w_op_be != 4'b0000));
   assign w_ram_we = w_cur_write ? w_op_be : 4'b0000;

   dmem_ram_array #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_ram (
      .i_clk   (clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (w_offset[AW+1:2]),
      .i_wdata (w_op_wdata),
      .o_rdata (w_ram_q)
   );

   // State register and wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_count <= 4'd0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_count <= 4'(WAIT_STATES);
         end else if (r_state == ST_BUSY) begin
            r_count <= r_count - 4'd1;
         end
      end
   end

   // Capture the request on accept so the bus is free to change during BUSY and DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_be       <= 4'd0;
         r_is_read  <= 1'b0;
         r_is_write <= 1'b0;
         r_fault    <= 1'b0;
      end else if (w_accept) begin
         r_addr     <= bus.dmem_addr;
         r_wdata    <= bus.dmem_wdata;
         r_be       <= bus.dmem_byte_enable;
         r_is_read  <= bus.dmem_read;
         r_is_write <= bus.dmem_write;
         r_fault    <= w_fault_now;
      end
   end

   // During DONE the RAM's registered word is presented directly; the hold register then keeps it
   always_comb begin
      w_rdata_out = r_rdata_hold;
      if (r_state == ST_DONE) begin
         if (r_fault) begin
            w_rdata_out = 32'd0;
         end else if (r_is_read) begin
            w_rdata_out = w_ram_q;
         end
      end
   end

   // Hold the presented load data until the next completion that changes it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata_hold <= 32'd0;
      end else if (r_state == ST_DONE) begin
         r_rdata_hold <= w_rdata_out;
      end
   end

   assign bus.dmem_ready = (r_state == ST_DONE);
   assign bus.dmem_error = (r_state == ST_DONE) && r_fault;
   assign bus.dmem_rdata = w_rdata_out;

endmodule
